// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-way round-robin arbiter with hold-until-release grants.
// Optional preemption after MAX_HOLD contended cycles when RR_ARBITER4_TIMEOUT_EN is defined.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] last_q, last_d;
    logic       valid_q, valid_d;
    logic [3:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] others;

`ifdef RR_ARBITER4_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
`else
    logic unused_max_hold;
    assign unused_max_hold = ^{8'(MAX_HOLD), hold_q};
`endif

    // First set bit strictly after 'after', wrapping 3 -> 0; 'after' itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] after);
        logic [1:0] idx;
        logic       found;
        rr_pick = after;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = after + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign others = req & ~(4'b0001 << idx_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, last_q);
                    last_d  = idx_d;
                    valid_d = 1'b1;
                    hold_d  = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (req[idx_q]) begin
                    hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
`ifdef RR_ARBITER4_TIMEOUT_EN
                    if (hold_q >= HOLD_LIMIT && |others) begin
                        idx_d  = rr_pick(others, idx_q);
                        last_d = idx_d;
                        hold_d = 8'd0;
                    end
`endif
                end else if (|req) begin
                    // Holder released; the releasing index is already lowest priority.
                    idx_d  = rr_pick(req, idx_q);
                    last_d = idx_d;
                    hold_d = 8'd0;
                end else begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        gnt_d  = valid_d ? (4'b0001 << idx_d) : 4'b0000;
        busy_d = valid_d && |(req & ~(4'b0001 << idx_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd3;
            valid_q <= 1'b0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - scoreboard bench for rr_arbiter4 against an integer reference model.
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: holder = -1 means nobody owns the resource.
    int holder = -1;
    int m_last = 3;
    int m_idx  = 0;
    int m_held = 0;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int first_after(input logic [3:0] r, input int start);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function void give(input int n);
        holder = n;
        m_last = n;
        m_idx  = n;
        m_held = 0;
    endfunction

    function void model_step(input logic r_rst, input logic [3:0] r);
        logic [3:0] oth;
        exp_t e;
        if (r_rst) begin
            holder = -1;
            m_last = 3;
            m_idx  = 0;
            m_held = 0;
        end else if (holder < 0) begin
            if (r != 4'b0000) give(first_after(r, m_last));
        end else if (!r[holder]) begin
            if (r != 4'b0000) give(first_after(r, holder));
            else holder = -1;
        end else begin
            oth = r;
            oth[holder] = 1'b0;
`ifdef RR_ARBITER4_TIMEOUT_EN
            if (m_held >= MAX_HOLD - 1 && oth != 4'b0000) give(first_after(oth, holder));
            else if (m_held < 255) m_held++;
`else
            if (m_held < 255) m_held++;
`endif
        end
        e.valid = (holder >= 0);
        e.idx   = 2'(m_idx);
        e.gnt   = e.valid ? (4'b0001 << m_idx) : 4'b0000;
        oth     = r;
        oth[m_idx] = 1'b0;
        e.busy  = e.valid && (oth != 4'b0000);
        exp_q.push_back(e);
    endfunction

    task automatic drive(input logic r_rst, input logic [3:0] r);
        @(negedge clk);
        rst = r_rst;
        req = r;
        model_step(r_rst, r);
    endtask

    // Monitor: every registered output update is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (gnt !== e.gnt) begin
                    errors++;
                    $display("FAIL gnt at %0t: got %b expected %b", $time, gnt, e.gnt);
                end
                checks++;
                if (gnt_valid !== e.valid) begin
                    errors++;
                    $display("FAIL gnt_valid at %0t: got %b expected %b", $time, gnt_valid, e.valid);
                end
                checks++;
                if (gnt_idx !== e.idx) begin
                    errors++;
                    $display("FAIL gnt_idx at %0t: got %b expected %b", $time, gnt_idx, e.idx);
                end
                checks++;
                if (busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy at %0t: got %b expected %b", $time, busy, e.busy);
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        // Reset then idle.
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0000);
        repeat (3) drive(1'b0, 4'b0000);
        // All requesting; each holder drops for one cycle after two granted cycles.
        for (int i = 0; i < 14; i++) begin
            r = 4'b1111;
            if (holder >= 0 && m_held == 1) r[holder] = 1'b0;
            drive(1'b0, r);
        end
        // Single requester then release to idle.
        drive(1'b1, 4'b0000);
        repeat (4) drive(1'b0, 4'b0100);
        repeat (2) drive(1'b0, 4'b0000);
        // Release by holder 1 on the same edge as req[3] rises.
        repeat (3) drive(1'b0, 4'b0010);
        repeat (2) drive(1'b0, 4'b1000);
        drive(1'b0, 4'b0000);
        // Reset mid-grant, then 2 must precede 3.
        repeat (2) drive(1'b0, 4'b0100);
        drive(1'b1, 4'b0100);
        repeat (3) drive(1'b0, 4'b1100);
        drive(1'b0, 4'b0000);
        // Constant contention: alternation with timeout, stuck holder without.
        repeat (20) drive(1'b0, 4'b0011);
        drive(1'b0, 4'b0000);
        // Randomized level-sensitive requests with occasional resets.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            drive(($urandom_range(199) == 0), r);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
